// File: rtl/demux1_4_buf_pkg.sv
// Shared widths, channel select type and helpers for the 1-to-4 buffered demux.
package demux1_4_buf_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned DEST_W     = 2;
  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned PTR_W      = 1;
  localparam int unsigned CNT_W      = 2;

  typedef enum logic [DEST_W-1:0] {
    CH_A = 2'd0,
    CH_B = 2'd1,
    CH_C = 2'd2,
    CH_D = 2'd3
  } ch_e;

  // Incoming word as seen by the router.
  typedef struct packed {
    ch_e               dest;
    logic [DATA_W-1:0] data;
  } in_word_t;

  // One-hot channel mask for a channel select.
  function automatic logic [NUM_CH-1:0] ch_onehot(input ch_e ch);
    ch_onehot = NUM_CH'(1) << ch;
  endfunction

endpackage

// File: rtl/demux1_4_buf_if.sv
// Producer and per-channel consumer handshakes of the buffered demux.
interface demux1_4_buf_if;
  import demux1_4_buf_pkg::*;

  logic [DATA_W-1:0] in_data;
  logic [DEST_W-1:0] in_dest;
  logic              in_valid;
  logic              in_ready;

  logic [DATA_W-1:0] outA_data;
  logic [DATA_W-1:0] outB_data;
  logic [DATA_W-1:0] outC_data;
  logic [DATA_W-1:0] outD_data;
  logic              outA_valid;
  logic              outB_valid;
  logic              outC_valid;
  logic              outD_valid;
  logic              outA_ready;
  logic              outB_ready;
  logic              outC_ready;
  logic              outD_ready;
  logic              busy;

  modport master (
    output in_data, in_dest, in_valid,
    output outA_ready, outB_ready, outC_ready, outD_ready,
    input  in_ready, busy,
    input  outA_data, outB_data, outC_data, outD_data,
    input  outA_valid, outB_valid, outC_valid, outD_valid
  );

  modport slave (
    input  in_data, in_dest, in_valid,
    input  outA_ready, outB_ready, outC_ready, outD_ready,
    output in_ready, busy,
    output outA_data, outB_data, outC_data, outD_data,
    output outA_valid, outB_valid, outC_valid, outD_valid
  );

endinterface

// File: rtl/demux_fifo2.sv
// Two-entry word FIFO with 1-bit wrapping pointers; head word is read straight from storage.
module demux_fifo2
  import demux1_4_buf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Guarded push/pop keep the count inside 0..FIFO_DEPTH even if a caller misbehaves.
  always_comb begin
    push_ok  = push_i && !full_o;
    pop_ok   = pop_i && !empty_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/demux1_4_buf.sv
// 1-to-4 demultiplexer routing each accepted word into a per-channel 2-entry FIFO.
module demux1_4_buf
  import demux1_4_buf_pkg::*;
(
  input  logic         Clk,
  input  logic         Reset_n,
  demux1_4_buf_if.slave bus
);

  in_word_t          in_w;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] cons_ready;
  logic [DATA_W-1:0] head [NUM_CH];
  logic [CNT_W-1:0]  cnt  [NUM_CH];
  logic              accept;

  assign in_w = '{dest: ch_e'(bus.in_dest), data: bus.in_data};

  // Readiness depends only on the addressed channel's fill level.
  assign bus.in_ready = !full[in_w.dest];
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = ch_onehot(in_w.dest) & {NUM_CH{accept}};

  assign cons_ready = {bus.outD_ready, bus.outC_ready, bus.outB_ready, bus.outA_ready};
  assign pop        = cons_ready & ~empty;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    demux_fifo2 u_fifo (
      .clk     (Clk),
      .rst_n   (Reset_n),
      .push_i  (push[c]),
      .pop_i   (pop[c]),
      .data_i  (in_w.data),
      .data_o  (head[c]),
      .full_o  (full[c]),
      .empty_o (empty[c]),
      .count_o (cnt[c])
    );
  end

  assign bus.outA_valid = !empty[CH_A];
  assign bus.outB_valid = !empty[CH_B];
  assign bus.outC_valid = !empty[CH_C];
  assign bus.outD_valid = !empty[CH_D];

  assign bus.outA_data = head[CH_A];
  assign bus.outB_data = head[CH_B];
  assign bus.outC_data = head[CH_C];
  assign bus.outD_data = head[CH_D];

  always_comb begin
    bus.busy = 1'b0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      bus.busy = bus.busy | (cnt[c] != '0);
    end
  end

endmodule
